// File: rtl/wwm_turn_ctrl_if.sv
// Launch/landing handshake between the turn sequencer (master) and the projectile animator (slave).
interface wwm_turn_ctrl_if;
    logic       launch;
    logic [3:0] vX_out;
    logic [3:0] vY_out;
    logic       anim_done;
    logic       hit;

    modport master (output launch, output vX_out, output vY_out, input anim_done, input hit);
    modport slave  (input launch, input vX_out, input vY_out, output anim_done, output hit);
endinterface

// File: rtl/wwm_turn_ctrl.sv
// Two-player turn sequencer for World War Math: latches shot velocity, launches, waits for
// landing or timeout, scores the shot and passes the turn until a player reaches MAX_SCORE.
module wwm_turn_ctrl #(
    parameter int MAX_SCORE   = 5,
    parameter int TIMEOUT_CYC = 200000000
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Fire,
    input  logic [7:0]            vel_sw,
    wwm_turn_ctrl_if.master       anim,
    output logic                  active_player,
    output logic [3:0]            score_p1,
    output logic [3:0]            score_p2,
    output logic                  winner,
    output logic                  q_I,
    output logic                  q_Aim,
    output logic                  q_Fly,
    output logic                  q_Score,
    output logic                  q_Done
);

    typedef enum logic [4:0] {
        S_I     = 5'b00001,
        S_AIM   = 5'b00010,
        S_FLY   = 5'b00100,
        S_SCORE = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam int             CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     SCORE_MAX = 4'(MAX_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fly_cnt;
    logic [3:0]       active_score;
    logic             new_game, shot_go, land_hit, turn_pass, game_won;

    assign active_score = active_player ? score_p2 : score_p1;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) state_q <= S_I;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        new_game  = 1'b0;
        shot_go   = 1'b0;
        land_hit  = 1'b0;
        turn_pass = 1'b0;
        game_won  = 1'b0;
        unique case (state_q)
            S_I, S_DONE: begin
                if (Start) begin
                    state_d  = S_AIM;
                    new_game = 1'b1;
                end
            end
            S_AIM: begin
                if (Fire && (vel_sw != 8'h00)) begin
                    state_d = S_FLY;
                    shot_go = 1'b1;
                end
            end
            S_FLY: begin
                // A landing report outranks a timeout in the same cycle.
                if (anim.anim_done) begin
                    state_d  = S_SCORE;
                    land_hit = anim.hit;
                end else if (fly_cnt == CNT_LAST) begin
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                if (active_score == SCORE_MAX) begin
                    state_d  = S_DONE;
                    game_won = 1'b1;
                end else begin
                    state_d   = S_AIM;
                    turn_pass = 1'b1;
                end
            end
            default: state_d = S_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            anim.launch   <= 1'b0;
            anim.vX_out   <= 4'd0;
            anim.vY_out   <= 4'd0;
            fly_cnt       <= '0;
            active_player <= 1'b0;
            score_p1      <= 4'd0;
            score_p2      <= 4'd0;
            winner        <= 1'b0;
        end else begin
            anim.launch <= shot_go;
            if (shot_go) begin
                anim.vX_out <= vel_sw[7:4];
                anim.vY_out <= vel_sw[3:0];
            end

            if (state_q == S_FLY && state_d == S_FLY) fly_cnt <= fly_cnt + 1'b1;
            else                                      fly_cnt <= '0;

            if (new_game) begin
                score_p1      <= 4'd0;
                score_p2      <= 4'd0;
                active_player <= 1'b0;
                winner        <= 1'b0;
            end
            // Scores saturate at the winning value rather than wrapping.
            if (land_hit && active_score < SCORE_MAX) begin
                if (active_player) score_p2 <= score_p2 + 4'd1;
                else               score_p1 <= score_p1 + 4'd1;
            end
            if (turn_pass) active_player <= ~active_player;
            if (game_won)  winner        <= active_player;
        end
    end

    assign q_I     = state_q[0];
    assign q_Aim   = state_q[1];
    assign q_Fly   = state_q[2];
    assign q_Score = state_q[3];
    assign q_Done  = state_q[4];

endmodule

// File: tb/tb_wwm_turn_ctrl.sv
// Directed bench for wwm_turn_ctrl with MAX_SCORE=2 and TIMEOUT_CYC=16.
module tb_wwm_turn_ctrl;

    localparam logic [4:0] F_I = 5'b00001, F_AIM = 5'b00010, F_FLY = 5'b00100,
                           F_SCORE = 5'b01000, F_DONE = 5'b10000;

    logic       clk = 1'b0;
    logic       Reset, Start, Fire;
    logic [7:0] vel_sw;
    logic       active_player, winner;
    logic [3:0] score_p1, score_p2;
    logic       q_I, q_Aim, q_Fly, q_Score, q_Done;
    logic [4:0] flags;
    int         n_tests = 0;
    int         n_fail  = 0;

    wwm_turn_ctrl_if anim_if ();

    wwm_turn_ctrl #(.MAX_SCORE(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .Fire(Fire), .vel_sw(vel_sw),
        .anim(anim_if.master),
        .active_player(active_player), .score_p1(score_p1), .score_p2(score_p2),
        .winner(winner), .q_I(q_I), .q_Aim(q_Aim), .q_Fly(q_Fly),
        .q_Score(q_Score), .q_Done(q_Done)
    );

    assign flags = {q_Done, q_Score, q_Fly, q_Aim, q_I};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Fire = 1'b0; vel_sw = 8'h00;
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        step(); step();
        Reset = 1'b0;
        check("rst_flags", flags, F_I);
        check("rst_launch", anim_if.launch, 0);
        check("rst_vel", {anim_if.vX_out, anim_if.vY_out}, 8'h00);
        check("rst_scores", {score_p1, score_p2, active_player, winner}, 0);

        // Fire in idle is ignored
        Fire = 1'b1; vel_sw = 8'h35;
        step();
        Fire = 1'b0;
        check("idle_fire_flags", flags, F_I);
        check("idle_fire_launch", anim_if.launch, 0);

        Start = 1'b1;
        step();
        Start = 1'b0;
        check("start_flags", flags, F_AIM);

        // Shot 1: P1 fires 0x35
        Fire = 1'b1; vel_sw = 8'h35;
        step();
        Fire = 1'b0; vel_sw = 8'hA7;
        check("t1_launch", anim_if.launch, 1);
        check("t1_vx", anim_if.vX_out, 4'd3);
        check("t1_vy", anim_if.vY_out, 4'd5);
        check("t1_flags", flags, F_FLY);
        step();
        check("t1_launch_pulse", anim_if.launch, 0);
        check("t1_vel_held", {anim_if.vX_out, anim_if.vY_out}, 8'h35);
        Fire = 1'b1; Start = 1'b1;
        step();
        Fire = 1'b0; Start = 1'b0;
        check("t3_fly_ignore_flags", flags, F_FLY);
        check("t3_fly_ignore_launch", anim_if.launch, 0);

        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("t2_score_p1", score_p1, 4'd1);
        check("t2_flags_score", flags, F_SCORE);
        step();
        check("t2_flags_aim", flags, F_AIM);
        check("t2_active", active_player, 1);

        // Zero velocity fire and Start in AIM are ignored
        vel_sw = 8'h00; Fire = 1'b1; Start = 1'b1;
        step();
        Fire = 1'b0; Start = 1'b0;
        check("t3_zero_flags", flags, F_AIM);
        check("t3_zero_launch", anim_if.launch, 0);
        check("t3_scores", {score_p1, score_p2}, 8'h10);

        // anim_done outside FLY is ignored
        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("aim_anim_flags", flags, F_AIM);
        check("aim_anim_scores", {score_p1, score_p2}, 8'h10);

        // P2 hits once
        vel_sw = 8'h12; Fire = 1'b1;
        step();
        Fire = 1'b0;
        check("p2_vel", {anim_if.launch, anim_if.vX_out, anim_if.vY_out}, 9'h112);
        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("p2_score", score_p2, 4'd1);
        step();
        check("p2_turn_back", {flags, 3'b000, active_player}, {F_AIM, 4'h0});

        // Timeout: P1 shot never lands; a stray hit without anim_done is ignored
        vel_sw = 8'hF0; Fire = 1'b1;
        step();
        Fire = 1'b0;
        check("t4_vel", {anim_if.vX_out, anim_if.vY_out}, 8'hF0);
        anim_if.hit = 1'b1;
        step();
        anim_if.hit = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("t4_still_fly", flags, F_FLY);
        step();
        check("t4_timeout_score", flags, F_SCORE);
        check("t4_scores", {score_p1, score_p2}, 8'h11);
        step();
        check("t4_turn_p2", {flags, 3'b000, active_player}, {F_AIM, 4'h1});

        // Test 5: P2 reaches MAX_SCORE=2
        vel_sw = 8'h44; Fire = 1'b1;
        step();
        Fire = 1'b0;
        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("t5_score_p2", score_p2, 4'd2);
        step();
        check("t5_done", flags, F_DONE);
        check("t5_winner", winner, 1);
        check("t5_active", active_player, 1);
        Fire = 1'b1; vel_sw = 8'h11;
        step();
        Fire = 1'b0;
        check("t5_done_fire", {flags, 3'b000, anim_if.launch}, {F_DONE, 4'h0});
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("t5_restart_flags", flags, F_AIM);
        check("t5_restart_scores", {score_p1, score_p2, 3'b000, active_player}, 12'h000);

        // anim_done on the final timeout cycle: landing wins and scores
        vel_sw = 8'h27; Fire = 1'b1;
        step();
        Fire = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("tie_fly", flags, F_FLY);
        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("tie_score", {flags, 3'b000, score_p1}, {F_SCORE, 7'h01});
        step();
        check("tie_turn", active_player, 1);

        // Test 6: reset in the middle of FLY
        vel_sw = 8'h21; Fire = 1'b1;
        step();
        Fire = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t6_flags", flags, F_I);
        check("t6_outputs", {anim_if.launch, anim_if.vX_out, anim_if.vY_out}, 9'h000);
        check("t6_state", {score_p1, score_p2, active_player, winner}, 0);
        anim_if.anim_done = 1'b1; anim_if.hit = 1'b1;
        step();
        anim_if.anim_done = 1'b0; anim_if.hit = 1'b0;
        check("t6_late_anim", {flags, score_p1, score_p2}, {F_I, 8'h00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
